// File: rtl/gray_seg_scan.sv
// Captures a WIDTH-bit value (optionally Gray-coded), converts it to BCD with a
// serial double-dabble FSM and scans the decimal digits onto a multiplexed 7-segment display.
module gray_seg_scan #(
    parameter int WIDTH    = 4,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  num_in,
    input  logic              load,
    input  logic              mode,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] dig_en,
    output logic              busy
);

    localparam int BW     = 4 * DIGITS;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int STEP_W = $clog2(WIDTH + 1);
    localparam logic [15:0]      PRE_TC   = 16'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t              state_r, state_next_s;
    logic [WIDTH-1:0]    shift_r, shift_next_s;
    logic [BW-1:0]       bcd_r, bcd_next_s, adj_s;
    logic [STEP_W-1:0]   step_r, step_next_s;
    logic [BW-1:0]       disp_r, disp_next_s;
    logic [15:0]         pre_r, pre_next_s;
    logic [IDX_W-1:0]    idx_r, idx_next_s;
    logic [6:0]          seg_r, seg_next_s;
    logic [DIGITS-1:0]   dig_en_r, onehot_s, blank_s;
    logic                busy_r, higher_nz_s, blk_s;
    logic [3:0]          nib_s;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = b[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Conversion FSM: next state, shift/BCD datapath and display capture.
    always_comb begin
        state_next_s = state_r;
        shift_next_s = shift_r;
        bcd_next_s   = bcd_r;
        step_next_s  = step_r;
        disp_next_s  = disp_r;
        adj_s        = dabble_adjust(bcd_r);
        case (state_r)
            IDLE: begin
                if (load) begin
                    state_next_s = CONV;
                    shift_next_s = mode ? num_in : (num_in ^ (num_in >> 1'b1));
                    bcd_next_s   = '0;
                    step_next_s  = STEP_W'(WIDTH);
                end else begin
                    state_next_s = IDLE;
                end
            end
            CONV: begin
                {bcd_next_s, shift_next_s} = {adj_s, shift_r} << 1'b1;
                step_next_s = step_r - 1'b1;
                if (step_r == STEP_W'(1)) begin
                    state_next_s = UPDATE;
                end else begin
                    state_next_s = CONV;
                end
            end
            UPDATE: begin
                disp_next_s  = bcd_r;
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Scan prescaler and digit index, free-running regardless of the FSM.
    always_comb begin
        pre_next_s = pre_r + 16'd1;
        idx_next_s = idx_r;
        if (pre_r == PRE_TC) begin
            pre_next_s = 16'd0;
            if (idx_r == IDX_LAST) begin
                idx_next_s = '0;
            end else begin
                idx_next_s = idx_r + 1'b1;
            end
        end else begin
            pre_next_s = pre_r + 16'd1;
            idx_next_s = idx_r;
        end
    end

    // Segment/enable values for the next cycle so the outputs can be registered without lag.
    always_comb begin
        higher_nz_s = 1'b0;
        blank_s     = '0;
        nib_s       = 4'd0;
        blk_s       = 1'b0;
        onehot_s    = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            higher_nz_s = higher_nz_s | (disp_next_s[4*k +: 4] != 4'd0);
            blank_s[k]  = (k != 0) && !higher_nz_s;
        end
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_next_s == IDX_W'(k)) begin
                nib_s       = disp_next_s[4*k +: 4];
                blk_s       = blank_s[k];
                onehot_s[k] = 1'b1;
            end else begin
                onehot_s[k] = 1'b0;
            end
        end
        seg_next_s = blk_s ? 7'b0000000 : seg_encode(nib_s);
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            shift_r  <= '0;
            bcd_r    <= '0;
            step_r   <= '0;
            disp_r   <= '0;
            pre_r    <= 16'd0;
            idx_r    <= '0;
            seg_r    <= 7'b1111110;
            dig_en_r <= {{(DIGITS-1){1'b0}}, 1'b1};
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            shift_r  <= shift_next_s;
            bcd_r    <= bcd_next_s;
            step_r   <= step_next_s;
            disp_r   <= disp_next_s;
            pre_r    <= pre_next_s;
            idx_r    <= idx_next_s;
            seg_r    <= seg_next_s;
            dig_en_r <= onehot_s;
            busy_r   <= (state_next_s != IDLE);
        end
    end

    assign seg    = seg_r;
    assign dig_en = dig_en_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_gray_seg_scan.sv
// Scoreboard bench for gray_seg_scan (WIDTH=8, DIGITS=3, SCAN_DIV=4): stimulus queues
// expected digit patterns, the monitor retires them when busy falls and checks every scan slot.
module tb_gray_seg_scan;

    localparam int W  = 8;
    localparam int D  = 3;
    localparam int SD = 4;

    localparam logic [6:0] S_BL = 7'b0000000;
    localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101;
    localparam logic [6:0] S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011;
    localparam logic [6:0] S8 = 7'b1111111;

    typedef struct {
        logic [6:0] d0;
        logic [6:0] d1;
        logic [6:0] d2;
        int         blen;
    } exp_t;

    logic         clk, rst_n, load, mode;
    logic [W-1:0] num_in;
    logic [6:0]   seg;
    logic [D-1:0] dig_en;
    logic         busy;

    exp_t       sb_q[$];
    logic [6:0] exp_disp [D];
    int         cmp_cnt = 0;
    int         mis_cnt = 0;
    int         edge_cnt;
    int         busy_len = 0;
    logic       prev_busy = 1'b0;
    logic       done = 1'b0;

    gray_seg_scan #(.WIDTH(W), .DIGITS(D), .SCAN_DIV(SD)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .num_in (num_in),
        .load   (load),
        .mode   (mode),
        .seg    (seg),
        .dig_en (dig_en),
        .busy   (busy)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Reference scan position: rising edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    task automatic chk(input string name, input int act, input int exp_v);
        cmp_cnt++;
        if (act != exp_v) begin
            mis_cnt++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: immediate reset checks, scoreboard retirement and per-slot display checks.
    always @(negedge clk or negedge rst_n) begin
        if (clk === 1'b1) begin
            #1;
            chk("rst_async_busy", int'(busy), 0);
            chk("rst_async_seg", int'(seg), int'(S0));
            chk("rst_async_dig_en", int'(dig_en), 1);
        end else if (clk === 1'b0) begin
            int   idx;
            exp_t it;
            if (!rst_n) begin
                sb_q.delete();
                exp_disp[0] = S0;
                exp_disp[1] = S_BL;
                exp_disp[2] = S_BL;
                prev_busy   = 1'b0;
                busy_len    = 0;
                chk("rst_busy", int'(busy), 0);
            end else begin
                if (busy) begin
                    busy_len++;
                    if (busy_len == 3 * (W + 1)) chk("busy_stuck", busy_len, W + 1);
                end else if (prev_busy) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_update", 1, 0);
                    end else begin
                        it = sb_q.pop_front();
                        chk("busy_len", busy_len, it.blen);
                        exp_disp[0] = it.d0;
                        exp_disp[1] = it.d1;
                        exp_disp[2] = it.d2;
                    end
                    busy_len = 0;
                end
                prev_busy = busy;
            end
            idx = (edge_cnt / SD) % D;
            chk("dig_en", int'(dig_en), 1 << idx);
            chk($sformatf("seg_digit%0d", idx), int'(seg), int'(exp_disp[idx]));
            if (done) begin
                chk("sb_empty", sb_q.size(), 0);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
                $finish;
            end
        end
    end

    task automatic push_exp(input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2);
        exp_t it;
        it.d0 = e0; it.d1 = e1; it.d2 = e2; it.blen = W + 1;
        sb_q.push_back(it);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && !busy; i++) @(negedge clk);
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_load(input logic [W-1:0] n, input logic m,
                           input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2);
        @(negedge clk);
        num_in = n; mode = m; load = 1'b1;
        push_exp(e0, e1, e2);
        @(negedge clk);
        load = 1'b0;
        wait_idle();
    endtask

    initial begin
        load = 1'b0; mode = 1'b0; num_in = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);

        do_load(8'd10,  1'b0, S5, S1, S_BL);   // Gray(10) = 15
        do_load(8'd255, 1'b1, S5, S5, S2);     // 255
        do_load(8'd255, 1'b0, S8, S2, S1);     // Gray(255) = 128

        // Inputs wiggling without load must not disturb the display.
        @(negedge clk); num_in = 8'd200; mode = 1'b1;
        repeat (6) @(negedge clk); mode = 1'b0;

        // Second load two cycles after the first lands while busy and is dropped.
        @(negedge clk); num_in = 8'd3; mode = 1'b1; load = 1'b1;
        push_exp(S3, S_BL, S_BL);
        @(negedge clk); load = 1'b0;
        @(negedge clk); num_in = 8'd9; mode = 1'b0; load = 1'b1;
        @(negedge clk); load = 1'b0;
        wait_idle();

        // Reset during the third busy cycle aborts the pending 7.
        @(negedge clk); num_in = 8'd7; mode = 1'b1; load = 1'b1;
        push_exp(S_BL, S_BL, S_BL);
        @(posedge clk); #1 load = 1'b0;
        @(posedge clk);
        @(posedge clk); #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (14) @(negedge clk);

        // Load held through reset is accepted on the first edge after release.
        @(posedge clk); #2 rst_n = 1'b0;
        @(negedge clk); num_in = 8'd42; mode = 1'b1; load = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        push_exp(S2, S4, S_BL);
        @(posedge clk); #1 load = 1'b0;
        wait_idle();

        repeat (12) @(negedge clk);
        done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gray_seg_scan.md
GRAY_SEG_SCAN -- requirements
Module: gray_seg_scan

Interface
REQ-001 Parameter WIDTH, default 4, input code width; legal range 4..8.
REQ-002 Parameter DIGITS, default 3, number of multiplexed 7-segment digits; SHALL satisfy 10^DIGITS > 2^WIDTH-1.
REQ-003 Parameter SCAN_DIV, default 1000, clk cycles per digit scan slot; legal range 2..65535.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 num_in  input  WIDTH  value to display; sampled only on an accepted load.
REQ-007 load  input  1  request to capture num_in; accepted only when busy=0.
REQ-008 mode  input  1  0: display Gray code of num_in (num_in ^ (num_in>>1)); 1: display num_in as plain binary; sampled with num_in.
REQ-009 seg  output  7  active-high segments {a,b,c,d,e,f,g}, a = bit 6.
REQ-010 dig_en  output  DIGITS  one-hot active-high digit enable; bit 0 = least significant decimal digit.
REQ-011 busy  output  1  high while a capture/conversion is in progress.

Function
REQ-012 FSM states IDLE, CONV, UPDATE; busy SHALL be 1 in CONV and UPDATE, 0 in IDLE.
REQ-013 IDLE: load=1 SHALL capture the mode-selected value into a shift register, clear BCD accumulator, load step counter with WIDTH, go to CONV.
REQ-014 CONV: one double-dabble step per cycle (add 3 to every BCD nibble >=5, then shift left one bit including value MSB); after WIDTH steps go to UPDATE.
REQ-015 UPDATE: BCD result SHALL be copied to the display registers in one cycle, then return to IDLE.
REQ-016 Latency: load accepted at edge N; display registers change at edge N+WIDTH+1; busy high for exactly WIDTH+1 cycles.
REQ-017 load while busy=1 SHALL be ignored; no queuing; display registers unchanged until UPDATE of the accepted request.
REQ-018 Display registers SHALL update atomically; no intermediate BCD value appears on seg.
REQ-019 Segment encoding: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011; non-BCD nibble => 0000000.
REQ-020 Leading-zero blanking: digit k>0 SHALL output 0000000 when it and all higher digits are zero; digit 0 always shown.
REQ-021 Scan: prescaler counts 0..SCAN_DIV-1; on terminal count, digit index advances, wrapping DIGITS-1 -> 0.
REQ-022 Scanning SHALL run continuously, independent of FSM state and load.
REQ-023 seg SHALL equal the encoded (or blanked) display digit selected by the current digit index; dig_en SHALL be one-hot of that index, never zero, never multi-hot.
REQ-024 mode and num_in changes outside an accepted load SHALL have no effect.

Reset
REQ-025 rst_n=0 SHALL immediately, regardless of state: FSM to IDLE, busy=0, display registers, BCD, step counter, prescaler and digit index to 0.
REQ-026 During and after reset: seg=1111110, dig_en=one-hot bit 0.
REQ-027 Reset during CONV/UPDATE SHALL abort conversion; the pending value is never displayed.
REQ-028 After rst_n deassertion, a load on the first clock edge SHALL be accepted.

Verification
REQ-029 Reset: drive rst_n=0 asynchronously mid-cycle -> seg=1111110, dig_en=001, busy=0 before next edge.
REQ-030 WIDTH=4, DIGITS=3, mode=0, num_in=10, load pulse -> busy high exactly 5 cycles; digit0 seg=1011011 ("5"), digit1 0110000 ("1"), digit2 0000000.
REQ-031 WIDTH=8, DIGITS=3, mode=1, num_in=255 -> digits 0/1/2 = 1011011, 1011011, 1101101 (255); mode=0, num_in=255 -> Gray 128: 1111111, 1101101, 0110000.
REQ-032 Load num_in=3 (mode=1), then load num_in=9 two cycles later while busy -> second ignored; display shows 3 (digit0 1111001), digits 1-2 blank.
REQ-033 SCAN_DIV=4 -> dig_en sequence 001,010,100,001 changing every 4 cycles, uninterrupted across loads.
REQ-034 Load num_in=7 (mode=1), assert rst_n=0 at third busy cycle -> busy=0 immediately, display remains 0 after release, 7 never appears.
